syncfifo_wr_arb: RTL
====================

Name: syncfifo_wr_arb

Overview:
- Round-robin write arbiter that shares one syncfifo write port among NUM_SRC valid/ready packet sources.
- Packet-atomic: once a source wins, it owns the FIFO until its last beat, so packets are never interleaved.
- The FIFO word is tagged with source ID and last flag.
- Sits directly in front of a syncfifo instance whose almost-full threshold is 1, meaning almost_full is high when at most one entry is free.

Parameters:
- NUM_SRC, 4, number of requesters (>=2).
- DATA_WIDTH, 8, payload width per beat.
- ID_WIDTH, $clog2(NUM_SRC), derived localparam; source-ID width.
- FIFO_WIDTH, DATA_WIDTH+ID_WIDTH+1, derived localparam; FIFO word width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- arb_en  in  1  enables new grants; an in-flight packet always completes.
- s_valid  in  NUM_SRC  per-source beat valid.
- s_data  in  NUM_SRC*DATA_WIDTH  per-source payload; source i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- s_last  in  NUM_SRC  per-source last-beat-of-packet.
- s_ready  out  NUM_SRC  per-source accept.
- fifo_din  out  FIFO_WIDTH  {last, src_id, data}, registered.
- fifo_wr_en  out  1  FIFO write strobe, registered.
- fifo_full  in  1  FIFO full.
- fifo_almost_full  in  1  FIFO almost full (free entries <= 1).
- busy  out  1  high in LOCK state.
- owner  out  ID_WIDTH  current or last granted source.

Behaviour:
- Reset (async assert): state=IDLE, rr_ptr=0, owner=0, fifo_wr_en=0, fifo_din=0, busy=0. s_ready=0 while rst_n low.
- Transfer: beat i is accepted on an edge where s_valid[i] && s_ready[i].
- Latency:
  - A beat accepted at edge t drives fifo_wr_en=1 and fifo_din={s_last[i], i, s_data[i]} during cycle t..t+1.
  - The FIFO writes it at edge t+1.
  - One beat per clock maximum.
- can_accept = !fifo_full && !(fifo_wr_en && fifo_almost_full). This covers the one registered write still in flight; the FIFO must never overflow.
- s_ready[i] = can_accept && grant[i]. s_ready may depend combinationally on s_valid and on the FIFO flags.
- FSM IDLE:
  - If arb_en && |s_valid, grant[i] goes to the first valid source searching rr_ptr, rr_ptr+1, ... with wrap modulo NUM_SRC.
  - Accepted beat with s_last=1: stay IDLE, rr_ptr=i+1 (wrap), owner=i.
  - Accepted beat with s_last=0: go to LOCK, owner=i.
  - Grant that is not accepted (FIFO full): no state change; arbitration is re-evaluated next cycle.
- FSM LOCK:
  - grant = onehot(owner) regardless of arb_en; all other s_ready stay 0.
  - Accepted beat with s_last=1: go to IDLE, rr_ptr=owner+1 (wrap).
  - An owner s_valid gap is legal: hold LOCK, no write.
- fifo_wr_en is 0 in every cycle following an edge with no accepted beat; fifo_din holds its value.
- arb_en deasserted in LOCK: the packet completes, then no grants until arb_en=1.
- busy = (state==LOCK).
- Simultaneous last beat and a new request from another source: the new source is arbitrated in the next cycle (IDLE), never in the same cycle.
- Reset mid-packet: the partial packet is abandoned. The FIFO-side reset is the FIFO's responsibility; both share rst_n.

Decomposition:
- Package syncfifo_arb_pkg:
  - state_t enum {IDLE, LOCK}.
  - function rr_next(ptr, n) for wrap increment.
- Sub-module rr_arb:
  - Purely combinational, parameter NUM_SRC.
  - Inputs: req vector, rr_ptr.
  - Outputs: onehot grant and grant index.
- The top level holds the FSM, pointer, output register and can_accept logic.

Test Plan:
Bench settings: NUM_SRC=4, DATA_WIDTH=8, syncfifo ADDR_WIDTH=4 (16 entries), TH_WR=1.
1. Reset check: rst_n low 200 ns, including an assert mid-cycle -> fifo_wr_en=0, s_ready=0000, busy=0, owner=0 immediately and throughout.
2. Round robin: all four sources hold s_valid with last=1, source i sends 8'h10+i, FIFO drained continuously -> FIFO IDs 0,1,2,3,0,1,... and no source starved.
3. Packet lock:
   - Stimulus: src1 sends 3 beats A1,A2,A3 (last on A3) with a one-cycle valid gap after A1; src2 is valid with B1 from the same cycle.
   - Response: FIFO order is A1,A2,A3,B1; busy is high from the edge after A1 until the edge accepting A3.
4. Backpressure:
   - Stimulus: no reads; src0 offers 20 single-beat packets 1..20.
   - Response: exactly 16 writes (1..16); fifo_wr_en is never high while full; s_ready[0] stays low thereafter.
   - Then one rd_en pulse -> exactly one more write (17).
5. arb_en drop: arb_en→0 after beat 1 of a 4-beat packet from src3 -> all 4 beats written, then zero grants for 10 cycles; arb_en→1 resumes with rr_ptr=0.
6. Reset mid-packet: rst_n low during beat 2 of a src2 packet -> state IDLE, rr_ptr=0, fifo_wr_en=0 asynchronously; after release, src0 is granted first.

Source files
------------

// File: rtl/syncfifo_wr_arb_pkg.sv
// Shared types and helpers for the syncfifo write arbiter.
// Holds the FSM state encoding and the round-robin pointer increment.
package syncfifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  function automatic int rr_next(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/syncfifo_wr_arb_if.sv
// Source-side valid/ready bundle plus the syncfifo write port, shared by arbiter and environment.
// master = arbiter side; slave = sources and FIFO.
interface syncfifo_wr_arb_if #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int ID_WIDTH   = $clog2(NUM_SRC);
  localparam int FIFO_WIDTH = DATA_WIDTH + ID_WIDTH + 1;

  logic [NUM_SRC-1:0]            s_valid;
  logic [NUM_SRC*DATA_WIDTH-1:0] s_data;
  logic [NUM_SRC-1:0]            s_last;
  logic [NUM_SRC-1:0]            s_ready;
  logic [FIFO_WIDTH-1:0]         fifo_din;
  logic                          fifo_wr_en;
  logic                          fifo_full;
  logic                          fifo_almost_full;

  modport master (
    input  s_valid, s_data, s_last, fifo_full, fifo_almost_full,
    output s_ready, fifo_din, fifo_wr_en
  );

  modport slave (
    output s_valid, s_data, s_last, fifo_full, fifo_almost_full,
    input  s_ready, fifo_din, fifo_wr_en
  );

endinterface

// File: rtl/syncfifo_wr_arb_rr_arb.sv
// Combinational round-robin picker: first asserted req at or after rr_ptr, wrapping.
// Zero latency; no state, grant is all-zero when nothing requests.
module rr_arb #(
  parameter  int NUM_SRC  = 4,
  localparam int ID_WIDTH = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0]  req,
  input  logic [ID_WIDTH-1:0] rr_ptr,
  output logic [NUM_SRC-1:0]  grant,
  output logic [ID_WIDTH-1:0] grant_idx
);

  int                  idx;
  logic [ID_WIDTH-1:0] cand;
  logic                found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    cand      = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      cand = ID_WIDTH'(idx);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/syncfifo_wr_arb.sv
// Packet-atomic round-robin arbiter feeding one syncfifo write port; one registered write per accepted beat.
// s_ready drops when the FIFO is full, or almost full with a write already in flight.
module syncfifo_wr_arb
  import syncfifo_arb_pkg::*;
#(
  parameter  int NUM_SRC    = 4,
  parameter  int DATA_WIDTH = 8,
  localparam int ID_WIDTH   = $clog2(NUM_SRC)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                arb_en,
  syncfifo_wr_arb_if.master   bus,
  output logic                busy,
  output logic [ID_WIDTH-1:0] owner
);

  localparam int FIFO_WIDTH = DATA_WIDTH + ID_WIDTH + 1;

  state_t                  state_q, state_d;
  logic [ID_WIDTH-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0]     owner_q, owner_d;
  logic                    wr_en_q, wr_en_d;
  logic [FIFO_WIDTH-1:0]   din_q, din_d;

  logic [NUM_SRC-1:0]      arb_grant;
  logic [ID_WIDTH-1:0]     arb_idx;
  logic [NUM_SRC-1:0]      grant;
  logic [NUM_SRC-1:0]      ready;
  logic [ID_WIDTH-1:0]     sel_idx;
  logic [DATA_WIDTH-1:0]   src_data [NUM_SRC];
  logic                    can_accept;
  logic                    accept;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_slice
    assign src_data[i] = bus.s_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_arb #(.NUM_SRC(NUM_SRC)) u_rr_arb (
    .req       (bus.s_valid & {NUM_SRC{arb_en}}),
    .rr_ptr    (rr_ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  // The registered write still in flight consumes the last free slot when almost full.
  assign can_accept = !bus.fifo_full && !(wr_en_q && bus.fifo_almost_full);

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    wr_en_d  = 1'b0;
    din_d    = din_q;
    grant    = '0;
    sel_idx  = owner_q;
    case (state_q)
      IDLE: begin
        grant   = arb_grant;
        sel_idx = arb_idx;
      end
      LOCK: grant[owner_q] = 1'b1;
      default: ;
    endcase
    ready  = grant & {NUM_SRC{can_accept & rst_n}};
    accept = |(ready & bus.s_valid);
    if (accept) begin
      wr_en_d = 1'b1;
      din_d   = {bus.s_last[sel_idx], sel_idx, src_data[sel_idx]};
      owner_d = sel_idx;
      if (bus.s_last[sel_idx]) begin
        state_d  = IDLE;
        rr_ptr_d = ID_WIDTH'(rr_next(int'(sel_idx), NUM_SRC));
      end else begin
        state_d  = LOCK;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      wr_en_q  <= 1'b0;
      din_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      wr_en_q  <= wr_en_d;
      din_q    <= din_d;
    end
  end

  assign bus.s_ready    = ready;
  assign bus.fifo_din   = din_q;
  assign bus.fifo_wr_en = wr_en_q;
  assign busy           = (state_q == LOCK);
  assign owner          = owner_q;

endmodule
